// File: rtl/sram_sequencer.sv
// sram_sequencer: one-command-at-a-time timed sequencer for an async SRAM bridge.
// Each command runs SETUP -> STROBE (ACCESS_CYCLES) -> RECOVER (TURN_CYCLES)
// -> IDLE. Every output, including the active-low bridge strobes, is a register.
module sram_sequencer #(
  parameter int ADDR_W        = 17,
  parameter int DATA_W        = 8,
  parameter int ACCESS_CYCLES = 2,
  parameter int TURN_CYCLES   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              s_chipselect_n,
  output logic              s_byteenable_n,
  output logic              s_write_n,
  output logic              s_read_n,
  output logic [ADDR_W-1:0] s_address,
  output logic [DATA_W-1:0] s_writedata,
  input  logic [DATA_W-1:0] s_readdata
);

  localparam int MAX_CYC  = (ACCESS_CYCLES > TURN_CYCLES) ? ACCESS_CYCLES : TURN_CYCLES;
  localparam int CNT_W    = $clog2(MAX_CYC) + 1;
  localparam int ACC_LOAD = ACCESS_CYCLES - 1;
  // TURN_CYCLES=0 never enters RECOVER; clamp so the load value stays non-negative.
  localparam int TRN_LOAD = (TURN_CYCLES > 0) ? (TURN_CYCLES - 1) : 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_STROBE  = 2'd2,
    ST_RECOVER = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                op_write_q, op_write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                ready_q, ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                busy_q, busy_d;
  logic                cs_n_q, cs_n_d;
  logic                be_n_q, be_n_d;
  logic                we_n_q, we_n_d;
  logic                oe_n_q, oe_n_d;
  logic                accept_s;

  // ready_q is only ever high in IDLE, so this is the full accept condition.
  assign accept_s = cmd_valid && ready_q;

  // Next-state, phase counter, command latch, read capture and next output values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_write_d  = op_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d    = ST_SETUP;
          op_write_d = cmd_write;
          addr_d     = cmd_addr;
          wdata_d    = cmd_wdata;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_d = ST_STROBE;
        cnt_d   = CNT_W'(ACC_LOAD);
      end
      ST_STROBE: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          // Final strobe edge: the bridge data is valid while OE_n is still low.
          if (!op_write_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = s_readdata;
          end else begin
            rsp_data_d  = rsp_data_q;
          end
          if (TURN_CYCLES > 0) begin
            state_d = ST_RECOVER;
            cnt_d   = CNT_W'(TRN_LOAD);
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_RECOVER: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so the registers line up with it.
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    cs_n_d  = !((state_d == ST_SETUP) || (state_d == ST_STROBE));
    be_n_d  = !((state_d == ST_SETUP) || (state_d == ST_STROBE));
    we_n_d  = !((state_d == ST_STROBE) && op_write_d);
    oe_n_d  = !((state_d == ST_STROBE) && !op_write_d);
  end

  // State, counter and registered outputs with synchronous reset to an idle bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      op_write_q  <= 1'b0;
      addr_q      <= {ADDR_W{1'b0}};
      wdata_q     <= {DATA_W{1'b0}};
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= {DATA_W{1'b0}};
      busy_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      be_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_write_q  <= op_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
      cs_n_q      <= cs_n_d;
      be_n_q      <= be_n_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
    end
  end

  assign cmd_ready      = ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign busy           = busy_q;
  assign s_chipselect_n = cs_n_q;
  assign s_byteenable_n = be_n_q;
  assign s_write_n      = we_n_q;
  assign s_read_n       = oe_n_q;
  assign s_address      = addr_q;
  assign s_writedata    = wdata_q;

endmodule

// File: tb/tb_sram_sequencer.sv
// Scoreboard bench for sram_sequencer: default timing instance (A) and an
// ACCESS=1/TURN=0 instance (B) for back-to-back reads.
module tb_sram_sequencer;

  localparam int ACC_A = 2;

  typedef struct packed {
    logic        write;
    logic [16:0] addr;
    logic [7:0]  data;
  } access_t;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } rsp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  // instance A signals
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [16:0] cmd_addr = 17'h0;
  logic [7:0]  cmd_wdata = 8'h0;
  logic        cmd_ready, rsp_valid, busy, cs_n, be_n, we_n, oe_n;
  logic [7:0]  rsp_data, s_writedata, s_readdata;
  logic [16:0] s_address;

  // instance B signals
  logic        cmd_valid_b = 1'b0;
  logic [16:0] cmd_addr_b = 17'h0;
  logic        cmd_ready_b, rsp_valid_b, busy_b, cs_n_b, be_n_b, we_n_b, oe_n_b;
  logic [7:0]  rsp_data_b, s_writedata_b, s_readdata_b;
  logic [16:0] s_address_b;

  access_t access_q[$];
  rsp_t    rsp_q[$];
  rsp_t    rsp_qb[$];

  function automatic logic [7:0] mem_model(input logic [16:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hB5;
  endfunction

  assign s_readdata   = mem_model(s_address);
  assign s_readdata_b = mem_model(s_address_b);

  sram_sequencer #(.ADDR_W(17), .DATA_W(8), .ACCESS_CYCLES(ACC_A), .TURN_CYCLES(1)) u_dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .s_chipselect_n(cs_n), .s_byteenable_n(be_n), .s_write_n(we_n), .s_read_n(oe_n),
    .s_address(s_address), .s_writedata(s_writedata), .s_readdata(s_readdata));

  sram_sequencer #(.ADDR_W(17), .DATA_W(8), .ACCESS_CYCLES(1), .TURN_CYCLES(0)) u_dut_b (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_write(1'b0), .cmd_addr(cmd_addr_b), .cmd_wdata(8'h00),
    .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .busy(busy_b),
    .s_chipselect_n(cs_n_b), .s_byteenable_n(be_n_b), .s_write_n(we_n_b), .s_read_n(oe_n_b),
    .s_address(s_address_b), .s_writedata(s_writedata_b), .s_readdata(s_readdata_b));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // {cs_n, be_n, we_n, oe_n, busy, cmd_ready, rsp_valid}
  task automatic bus_vec(input string name, input logic [6:0] exp);
    check(name, {25'd0, cs_n, be_n, we_n, oe_n, busy, cmd_ready, rsp_valid}, {25'd0, exp});
  endtask

  task automatic issue(input logic wr, input logic [16:0] a, input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check("issue_ready_timeout", {31'd0, cmd_ready}, 32'd1);
    end else begin
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      access_q.push_back('{wr, a, d});
      if (!wr) rsp_q.push_back('{mem_model(a), cyc + ACC_A + 1});
    end
  endtask

  // Response monitor A: every rsp_valid must match a queued read, on time.
  always @(negedge clk) begin
    rsp_t e;
    if (rsp_valid) begin
      if (rsp_q.size() == 0) begin
        check("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
      end else begin
        e = rsp_q.pop_front();
        check("rsp_data", {24'd0, rsp_data}, {24'd0, e.data});
        check("rsp_cycle", cyc, e.cyc);
      end
    end
  end

  // Response monitor B: back-to-back reads, rsp_valid coincides with cmd_ready.
  always @(negedge clk) begin
    rsp_t e;
    if (rsp_valid_b) begin
      if (rsp_qb.size() == 0) begin
        check("b_rsp_unexpected", {31'd0, rsp_valid_b}, 32'd0);
      end else begin
        e = rsp_qb.pop_front();
        check("b_rsp_data", {24'd0, rsp_data_b}, {24'd0, e.data});
        check("b_rsp_cycle", cyc, e.cyc);
        check("b_ready_with_rsp", {31'd0, cmd_ready_b}, 32'd1);
      end
    end
  end

  // Bus monitor A: each SETUP consumes one expected access; strobe kind,
  // length, address and write data are checked against it.
  access_t cur;
  logic    have_cur = 1'b0;
  logic    in_strobe = 1'b0;
  int      strobe_len = 0;
  always @(negedge clk) begin
    if (!we_n || !oe_n) check("strobe_exclusive", {30'd0, we_n, oe_n} , (!we_n) ? 32'd1 : 32'd2);
    if (!cs_n && we_n && oe_n && !in_strobe) begin
      if (access_q.size() == 0) begin
        check("extra_bus_access", 32'd1, 32'd0);
      end else begin
        cur = access_q.pop_front();
        have_cur = 1'b1;
      end
    end
    if (!we_n || !oe_n) begin
      if (!in_strobe) begin
        in_strobe = 1'b1;
        strobe_len = 0;
        check("strobe_kind", {31'd0, !we_n}, {31'd0, cur.write});
      end
      strobe_len++;
      check("strobe_cs_be", {30'd0, cs_n, be_n}, 32'd0);
    end else if (in_strobe) begin
      in_strobe = 1'b0;
      check("strobe_len", strobe_len, ACC_A);
    end
    if (busy && have_cur) begin
      check("addr_stable", {15'd0, s_address}, {15'd0, cur.addr});
      check("wdata_stable", {24'd0, s_writedata}, {24'd0, cur.data});
    end
    if (!busy) have_cur = 1'b0;
  end

  logic [6:0] wr_vec [5];
  logic [6:0] rd_vec [5];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int accepts, last_ac;
    wr_vec = '{7'b0011100, 7'b0001100, 7'b0001100, 7'b1111100, 7'b1111010};
    rd_vec = '{7'b0011100, 7'b0010100, 7'b0010100, 7'b1111101, 7'b1111010};

    // 1. reset for 3 cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus_vec("reset_state", 7'b1111000);
    check("reset_addr", {15'd0, s_address}, 32'd0);
    check("reset_wdata", {24'd0, s_writedata}, 32'd0);
    check("reset_rsp_data", {24'd0, rsp_data}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    bus_vec("ready_after_reset", 7'b1111010);

    // 2. write 1ABCD <= 5A
    issue(1'b1, 17'h1ABCD, 8'h5A);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus_vec($sformatf("write_seq_%0d", i), wr_vec[i]);
    end

    // 3. read 00010 -> A5
    issue(1'b0, 17'h00010, 8'h11);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus_vec($sformatf("read_seq_%0d", i), rd_vec[i]);
    end
    check("read_rsp_hold", {24'd0, rsp_data}, 32'hA5);

    // 4. back-to-back reads on instance B, cmd_valid held high
    @(posedge clk);
    #1;
    cmd_valid_b = 1'b1;
    cmd_addr_b = 17'h00100;
    accepts = 0;
    last_ac = -1;
    for (int k = 0; k < 40 && accepts < 5; k++) begin
      @(negedge clk);
      if (cmd_ready_b) begin
        @(posedge clk);
        #1;
        rsp_qb.push_back('{mem_model(cmd_addr_b), cyc + 2});
        if (last_ac >= 0) check("b2b_interval", cyc - last_ac, 32'd3);
        last_ac = cyc;
        accepts++;
        cmd_addr_b = cmd_addr_b + 17'h00111;
      end
    end
    cmd_valid_b = 1'b0;
    check("b2b_accepts", accepts, 32'd5);
    repeat (4) @(negedge clk);
    check("b2b_rsp_drained", rsp_qb.size(), 32'd0);

    // 5. reset during 2nd STROBE cycle of a write, then of a read
    for (int t = 0; t < 2; t++) begin
      issue(t == 0, (t == 0) ? 17'h000F0 : 17'h00033, 8'h3C);
      @(posedge clk);                 // SETUP -> STROBE 1
      @(posedge clk);                 // STROBE 2 begins
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      if (t == 1) rsp_q.delete();
      @(negedge clk);
      bus_vec($sformatf("abort_%0d_idle", t), 7'b1111000);
      @(negedge clk);
      bus_vec($sformatf("abort_%0d_ready", t), 7'b1111010);
    end

    // 6. cmd_valid pulses while busy are ignored
    issue(1'b1, 17'h01234, 8'h77);
    @(negedge clk);
    check("busy_during_pulse", {31'd0, busy}, 32'd1);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 17'h00555;
    repeat (2) @(negedge clk);
    cmd_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("no_extra_access", access_q.size(), 32'd0);
    check("no_pending_rsp", rsp_q.size(), 32'd0);
    check("idle_at_end", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
